// File: rtl/fp_pack_round.sv
// Iterative normalize / round-to-nearest-even / pack stage for IEEE-754 single precision.
// One normalization shift per cycle; the packed result is held behind a valid/ready handshake.
module fp_pack_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        inexact,
  output logic        underflow,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_reg, state_next;
  logic               sign_reg, sign_next;
  logic signed [10:0] exp_reg, exp_next;
  logic [47:0]        mant_reg, mant_next;
  logic               sticky_reg, sticky_next;
  logic [31:0]        result_reg, result_next;
  logic               inexact_reg, inexact_next;
  logic               underflow_reg, underflow_next;
  logic               overflow_reg, overflow_next;
  logic               out_valid_reg, out_valid_next;

  // Rounding datapath, evaluated from the normalized mantissa window.
  logic [23:0]        sig;
  logic               guard, st, round_up, rnd_inexact, rnd_ovf;
  logic [24:0]        sig_inc;
  logic [23:0]        sig_rnd;
  logic signed [10:0] exp_rnd, field;

  always_comb begin
    sig         = mant_reg[46:23];
    guard       = mant_reg[22];
    st          = sticky_reg | (|mant_reg[21:0]);
    round_up    = guard & (st | sig[0]);
    rnd_inexact = guard | st;
    sig_inc     = {1'b0, sig} + {24'd0, round_up};
    if (sig_inc[24]) begin
      sig_rnd = sig_inc[24:1];
      exp_rnd = exp_reg + 11'sd1;
    end else begin
      sig_rnd = sig_inc[23:0];
      exp_rnd = exp_reg;
    end
    // Without the hidden bit the value is subnormal (or zero) and encodes with field 0.
    field   = sig_rnd[23] ? exp_rnd : 11'sd0;
    rnd_ovf = (field >= 11'sd255);
  end

  always_comb begin
    state_next     = state_reg;
    sign_next      = sign_reg;
    exp_next       = exp_reg;
    mant_next      = mant_reg;
    sticky_next    = sticky_reg;
    result_next    = result_reg;
    inexact_next   = inexact_reg;
    underflow_next = underflow_reg;
    overflow_next  = overflow_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next   = in_sign;
          exp_next    = {in_exp[9], in_exp};
          mant_next   = in_mant;
          sticky_next = 1'b0;
          state_next  = NORM;
        end
      end
      NORM: begin
        if (mant_reg == 48'd0) begin
          state_next = ROUND;
        end else if (mant_reg[47] || (exp_reg < 11'sd1)) begin
          // Right shifts either drop the overflow bit or denormalize toward exponent 1.
          mant_next   = {1'b0, mant_reg[47:1]};
          sticky_next = sticky_reg | mant_reg[0];
          exp_next    = exp_reg + 11'sd1;
        end else if (!mant_reg[46] && (exp_reg > 11'sd1)) begin
          mant_next = {mant_reg[46:0], 1'b0};
          exp_next  = exp_reg - 11'sd1;
        end else begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        if (rnd_ovf) begin
          result_next    = {sign_reg, 8'hFF, 23'd0};
          inexact_next   = 1'b1;
          underflow_next = 1'b0;
          overflow_next  = 1'b1;
        end else begin
          result_next    = {sign_reg, field[7:0], sig_rnd[22:0]};
          inexact_next   = rnd_inexact;
          underflow_next = (field == 11'sd0) & rnd_inexact;
          overflow_next  = 1'b0;
        end
        out_valid_next = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sign_reg      <= 1'b0;
      exp_reg       <= 11'sd0;
      mant_reg      <= 48'd0;
      sticky_reg    <= 1'b0;
      result_reg    <= 32'd0;
      inexact_reg   <= 1'b0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sign_reg      <= sign_next;
      exp_reg       <= exp_next;
      mant_reg      <= mant_next;
      sticky_reg    <= sticky_next;
      result_reg    <= result_next;
      inexact_reg   <= inexact_next;
      underflow_reg <= underflow_next;
      overflow_reg  <= overflow_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign inexact   = inexact_reg;
  assign underflow = underflow_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fp_pack_round.sv
// Bench for fp_pack_round: directed vector table, reset/stall sequences and randomized
// operands checked against an exact-arithmetic round-to-nearest-even model.
module tb_fp_pack_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        inexact, underflow, overflow;

  fp_pack_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .inexact(inexact), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  // Exact model: value = m * 2^(e-173). Locate the leading one, choose the result exponent
  // (clamped to 1 for subnormals), split into quotient/remainder at the result LSB and round.
  function automatic void ref_model(input logic s, input logic [9:0] e10, input logic [47:0] m,
                                    output logic [31:0] r, output logic [2:0] f, output int k);
    int e, p, ee, sh, field;
    longint unsigned q, rem, half;
    bit inx, up;
    e = $signed(e10);
    if (m == 48'd0) begin
      r = {s, 31'd0};
      f = 3'b000;
      k = 0;
      return;
    end
    p = 47;
    while (p > 0 && !m[p]) p--;
    ee = p + e - 46;
    if (ee < 1) ee = 1;
    if (ee > e) k = (ee - e < p + 1) ? ee - e : p + 1;
    else        k = e - ee;
    sh = ee - e + 23;
    if (sh <= 0) begin
      q = longint'(m) << (-sh); rem = 0; half = 1;
    end else if (sh >= 60) begin
      q = 0; rem = longint'(m); half = 64'h8000_0000_0000_0000;
    end else begin
      q = longint'(m) >> sh;
      rem = longint'(m) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    inx = (rem != 0);
    up  = (rem > half) || ((rem == half) && q[0]);
    if (up) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      ee++;
    end
    field = (q >= (64'd1 << 23)) ? ee : 0;
    if (field >= 255) begin
      r = {s, 8'hFF, 23'd0};
      f = 3'b101;
    end else begin
      r = {s, field[7:0], q[22:0]};
      f = {inx, (field == 0) && inx, 1'b0};
    end
  endfunction

  // One full transaction; in_valid stays high with junk operands while busy to show it is ignored.
  task automatic do_op(input string name, input logic s, input logic [9:0] e, input logic [47:0] m,
                       input int hold, input logic [31:0] exp_r, input logic [2:0] exp_f,
                       input int exp_lat);
    int lat;
    @(negedge clk);
    check({name, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_sign = 1'($urandom); in_exp = 10'($urandom); in_mant = {16'($urandom), 32'($urandom)};
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, 64'(result), 64'(exp_r));
    check({name, " flags"}, 64'({inexact, underflow, overflow}), 64'(exp_f));
    $display("op %-12s sign=%0d exp=%0d mant=%012h -> result=%08h flags=%03b lat=%0d",
             name, s, $signed(e), m, result, {inexact, underflow, overflow}, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " stall result"}, 64'(result), 64'(exp_r));
      check({name, " stall flags"}, 64'({inexact, underflow, overflow}), 64'(exp_f));
      check({name, " stall valid/ready"}, 64'({out_valid, in_ready}), 64'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " post-accept valid/ready"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  typedef struct {
    string       name;
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    int          hold;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] mr;
    logic [2:0]  mf;
    int          mk;
    logic [63:0] rr;
    logic [47:0] m;
    logic [23:0] sg;
    int          e, mode;
    logic        s;

    vecs[0]  = '{"one",       1'b0, 10'd127, 48'h4000_0000_0000, 0, 32'h3F80_0000, 3'b000, 2};
    vecs[1]  = '{"two",       1'b0, 10'd127, 48'h8000_0000_0000, 0, 32'h4000_0000, 3'b000, 3};
    vecs[2]  = '{"lshift6",   1'b0, 10'd127, 48'h0100_0000_0000, 0, 32'h3C80_0000, 3'b000, 8};
    vecs[3]  = '{"tie_even",  1'b0, 10'd127, 48'h4000_0040_0000, 0, 32'h3F80_0000, 3'b100, 2};
    vecs[4]  = '{"tie_odd",   1'b0, 10'd127, 48'h4000_00C0_0000, 0, 32'h3F80_0002, 3'b100, 2};
    vecs[5]  = '{"overflow",  1'b0, 10'd300, 48'h4000_0000_0000, 0, 32'h7F80_0000, 3'b101, 2};
    vecs[6]  = '{"subnorm",   1'b0, 10'h3FF, 48'h4000_0000_0000, 0, 32'h0020_0000, 3'b000, 4};
    vecs[7]  = '{"tiny_neg",  1'b1, 10'h3E2, 48'h4000_0000_0000, 0, 32'h8000_0000, 3'b110, 33};
    vecs[8]  = '{"zero",      1'b0, 10'd127, 48'h0000_0000_0000, 0, 32'h0000_0000, 3'b000, 2};
    vecs[9]  = '{"carry_out", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 0, 32'h4000_0000, 3'b100, 2};
    vecs[10] = '{"sub_to_nrm",1'b0, 10'd1,   48'h3FFF_FFC0_0000, 0, 32'h0080_0000, 3'b100, 2};
    vecs[11] = '{"stall_max", 1'b1, 10'd254, 48'h7FFF_FFC0_0000, 5, 32'hFF80_0000, 3'b101, 2};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 10'd0; in_mant = 48'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid/ready", 64'({out_valid, in_ready}), 64'b01);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'({inexact, underflow, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].hold,
            vecs[i].r, vecs[i].f, vecs[i].lat);

    // Reset in the middle of a long normalization, then a clean operation.
    @(negedge clk);
    in_sign = 1'b1; in_exp = 10'h3E2; in_mant = 48'h4000_0000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset valid/ready", 64'({out_valid, in_ready}), 64'b01);
    check("mid reset result", 64'(result), 64'd0);
    check("mid reset flags", 64'({inexact, underflow, overflow}), 64'd0);
    $display("op %-12s reset asserted during NORM", "mid_reset");
    @(negedge clk);
    rst = 1'b0;
    do_op("after_reset", 1'b0, 10'd127, 48'h4000_0000_0000, 0, 32'h3F80_0000, 3'b000, 2);

    for (int n = 0; n < 300; n++) begin
      mode = int'($urandom_range(0, 4));
      s    = 1'($urandom);
      rr   = {$urandom(), $urandom()};
      m    = rr[47:0] >> $urandom_range(0, 47);
      case (mode)
        0:       e = 127 + int'($urandom_range(0, 100)) - 50;
        1:       e = int'($urandom_range(0, 1023)) - 512;
        2:       e = int'($urandom_range(0, 60)) - 30;
        3:       e = 230 + int'($urandom_range(0, 50));
        default: begin
          sg = 24'($urandom) | 24'h80_0000;
          m  = {1'b0, sg, 1'b1, 22'd0};
          e  = 127;
        end
      endcase
      ref_model(s, 10'(e), m, mr, mf, mk);
      do_op($sformatf("rnd%0d", n), s, 10'(e), m, int'($urandom_range(0, 2)), mr, mf, mk + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
